// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single DataMem port: M0 has priority, M1 gets locked bursts
// and a forced beat after waiting too long. Read data returns one cycle after the grant.
module dmem_arbiter #(
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [31:0] m0_pc,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_we,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_we,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] dm_pc,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_we,
  input  logic [31:0] dm_rdata
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned SW = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} owner_e;

  owner_e         owner_q, owner_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic           rvalid0_q, rvalid1_q;
  logic [31:0]    rdata0_q, rdata1_q;
  logic           burst0, burst1, gnt0, gnt1, cont, lock_sel;

  // Grant selection; reset gates grants so nothing reaches DataMem while held in reset.
  always_comb begin
    burst0 = (owner_q == StOwn0) && m0_req && (beat_q < BW'(MAX_BURST));
    burst1 = (owner_q == StOwn1) && m1_req && (beat_q < BW'(MAX_BURST));
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    if (reset) begin
      if (burst0) begin
        gnt0 = 1'b1;
      end else if (burst1) begin
        gnt1 = 1'b1;
      end else if (m1_req && (starve_q == SW'(STARVE_LIM))) begin
        gnt1 = 1'b1;
      end else if (m0_req) begin
        gnt0 = 1'b1;
      end else if (m1_req) begin
        gnt1 = 1'b1;
      end
    end
    cont = (gnt0 && burst0) || (gnt1 && burst1);
  end

  // Ownership is kept only while locked and below the burst limit; anything else idles.
  always_comb begin
    owner_d  = StIdle;
    beat_d   = '0;
    lock_sel = gnt0 ? m0_lock : m1_lock;
    if (gnt0 || gnt1) begin
      beat_d = cont ? beat_q + BW'(1) : BW'(1);
      if (lock_sel && (beat_d < BW'(MAX_BURST))) begin
        owner_d = gnt0 ? StOwn0 : StOwn1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!m1_req || gnt1) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_LIM)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_comb begin
    dm_pc    = '0;
    dm_addr  = '0;
    dm_wdata = '0;
    dm_we    = '0;
    if (gnt0) begin
      dm_pc    = m0_pc;
      dm_addr  = m0_addr;
      dm_wdata = m0_wdata;
      dm_we    = m0_we;
    end else if (gnt1) begin
      dm_addr  = m1_addr;
      dm_wdata = m1_wdata;
      dm_we    = m1_we;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q   <= StIdle;
      beat_q    <= '0;
      starve_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      owner_q   <= owner_d;
      beat_q    <= beat_d;
      starve_q  <= starve_d;
      rvalid0_q <= gnt0 && (m0_we == 4'h0);
      rvalid1_q <= gnt1 && (m1_we == 4'h0);
      if (gnt0 && (m0_we == 4'h0)) rdata0_q <= dm_rdata;
      if (gnt1 && (m1_we == 4'h0)) rdata1_q <= dm_rdata;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule
